// File: rtl/contador_bcd_param.sv
// -----------------------------------------------------------------------------
// contador_bcd_param
//
// Two-digit BCD up/down counter. Each RTC field (seconds, minutes, hours, day,
// month, year) uses one instance configured for its own range. Instances are
// chained through tick/carry, and the upper limit can come from max_in (for
// example, day-of-month driven by the month field).
//
// The count is held internally as a 7-bit binary value. It is converted to BCD
// combinationally on the way out.
//
// Parameters:
//   MIN_VAL   lowest count value (decimal, 0..98)
//   MAX_VAL   highest count value (decimal), used when DYN_MAX = 0
//   FIELD_ID  en_count code that selects this field for manual adjust
//   DYN_MAX   1 = effective maximum taken from max_in, clipped to [MIN_VAL, 99]
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset, highest priority
//   en_count   field-select code from the adjust FSM
//   enUP       manual increment request (level, one step per cycle)
//   enDOWN     manual decrement request (level, one step per cycle)
//   tick       single-cycle increment from the lower field's carry
//   load       parallel-load strobe
//   load_data  BCD value to load, {tens, units}
//   max_in     binary dynamic maximum (DYN_MAX = 1 only)
//   data_BCD   current value in BCD, {tens, units}
//   carry      one-cycle pulse after a tick-driven wrap
//   load_err   one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module contador_bcd_param #(
    parameter int MIN_VAL  = 1,
    parameter int MAX_VAL  = 12,
    parameter int FIELD_ID = 5,
    parameter int DYN_MAX  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] en_count,
    input  logic       enUP,
    input  logic       enDOWN,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic [6:0] max_in,
    output logic [7:0] data_BCD,
    output logic       carry,
    output logic       load_err
);

    localparam logic [6:0] MIN_Q  = 7'(MIN_VAL);
    localparam logic [6:0] MAX_Q  = 7'(MAX_VAL);
    localparam logic [6:0] TOP_Q  = 7'd99;
    localparam logic [3:0] FID_Q  = 4'(FIELD_ID);

    logic [6:0] q;
    logic [6:0] q_next;
    logic       carry_next;
    logic       err_next;

    logic [6:0] max_eff;
    logic [6:0] load_val;
    logic       load_ok;
    logic       selected;
    logic       adj_up;
    logic       adj_down;
    logic       at_max;
    logic       at_min;

    // Effective maximum. A dynamic limit is clipped into [MIN_VAL, 99], so a
    // garbage max_in can never produce an empty or non-BCD range.
    // NOTE: every variable assigned in always_comb gets a value on every path
    // (here via the defaults at the top); a missed path would infer a latch.
    always_comb begin
        max_eff = MAX_Q;
        if (DYN_MAX != 0) begin
            if (max_in < MIN_Q) begin
                max_eff = MIN_Q;
            end else if (max_in > TOP_Q) begin
                max_eff = TOP_Q;
            end else begin
                max_eff = max_in;
            end
        end
    end

    // Decoded load value. It is only meaningful when both nibbles are <= 9,
    // and that same condition gates load_ok, so any overflow for illegal
    // nibbles never reaches q.
    assign load_val = {3'b000, load_data[7:4]} * 7'd10 + {3'b000, load_data[3:0]};
    assign load_ok  = (load_data[7:4] <= 4'd9) && (load_data[3:0] <= 4'd9) &&
                      (load_val >= MIN_Q) && (load_val <= max_eff);

    // Manual adjust requires this field to be selected and exactly one
    // direction to be requested; asking for both directions does nothing.
    assign selected = (en_count == FID_Q);
    assign adj_up   = selected && enUP && !enDOWN;
    assign adj_down = selected && enDOWN && !enUP;

    // Inclusive compares, so that an out-of-range q still wraps back into range.
    assign at_max = (q >= max_eff);
    assign at_min = (q <= MIN_Q);

    always_comb begin
        q_next     = q;
        carry_next = 1'b0;
        err_next   = 1'b0;
        if (load) begin
            if (load_ok) begin
                q_next = load_val;
            end else begin
                err_next = 1'b1;
            end
        end else if (adj_up) begin
            // Manual wraps never raise carry, so adjusting a field leaves the
            // fields above it untouched.
            q_next = at_max ? MIN_Q : q + 7'd1;
        end else if (adj_down) begin
            q_next = at_min ? max_eff : q - 7'd1;
        end else if (tick) begin
            if (at_max) begin
                q_next     = MIN_Q;
                carry_next = 1'b1;
            end else begin
                q_next = q + 7'd1;
            end
        end else if (q > max_eff) begin
            // The dynamic limit shrank below the current value. Pull q down to
            // the limit without a carry.
            q_next = max_eff;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= MIN_Q;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= q_next;
            carry    <= carry_next;
            load_err <= err_next;
        end
    end

    // Binary to BCD, combinational, zero latency from q.
    assign data_BCD = {4'(q / 7'd10), 4'(q % 7'd10)};

endmodule
